// File: rtl/dsp_pkg.sv
// Shared DSP datapath types: sequencer state encoding and default word width.
package dsp_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam int DEFAULT_WIDTH = 48;

endpackage

// File: rtl/add_word_cy.sv
// One word of the carry chain: a + b + cin, with the carry-out as the extra top bit.
module add_word_cy
   import dsp_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] s,
   output logic             cout
);

   // Kept separate so the post-adder primitive can later replace it.
   assign {cout, s} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/carry_chain_seq.sv
// Multi-word adder sequencer: adds NWORDS operand words LS-first, feeding each
// registered carry-out back into the next word, behind a single-entry output buffer.
module carry_chain_seq
   import dsp_pkg::*;
#(
   parameter int WIDTH  = DEFAULT_WIDTH,
   parameter int NWORDS = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             cin_init,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carryout,
   output logic             carryoutf,
   output logic             busy,
   output logic             done
);

   localparam int CNT_W = $clog2(NWORDS) + 1;
   localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NWORDS - 1);

   state_t           state;
   logic             carry_reg;
   logic [CNT_W-1:0] word_cnt;
   logic [WIDTH-1:0] word_sum;
   logic             word_cout;
   logic             accept;

   add_word_cy #(.WIDTH(WIDTH)) u_add (
      .a    (a),
      .b    (b),
      .cin  (carry_reg),
      .s    (word_sum),
      .cout (word_cout)
   );

   // A new word may enter only when the output slot is empty or drains this cycle.
   assign in_ready = (state == RUN) && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;
   assign busy     = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         carry_reg <= 1'b0;
         word_cnt  <= '0;
         sum       <= '0;
         carryout  <= 1'b0;
         carryoutf <= 1'b0;
         out_valid <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  carry_reg <= cin_init;
                  word_cnt  <= '0;
                  state     <= RUN;
               end
            end
            RUN: begin
               if (accept) begin
                  sum       <= word_sum;
                  carryout  <= word_cout;
                  carry_reg <= word_cout;
                  out_valid <= 1'b1;
                  word_cnt  <= word_cnt + 1'b1;
                  if (word_cnt == LAST_WORD) begin
                     carryoutf <= word_cout;
                     state     <= DRAIN;
                  end
               end else if (out_ready) begin
                  out_valid <= 1'b0;
               end
            end
            DRAIN: begin
               if (out_valid && out_ready) begin
                  out_valid <= 1'b0;
                  done      <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_carry_chain_seq.sv
// Randomised bench for carry_chain_seq: the whole operation is modelled as one wide
// (NWORDS*WIDTH)-bit addition and every streamed word is checked against its slice.
module tb_carry_chain_seq;

   localparam int W  = 48;
   localparam int NW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start, cin_init, in_valid, out_ready;
   logic [W-1:0]  a, b;
   logic          in_ready, out_valid, carryout, carryoutf, busy, done;
   logic [W-1:0]  sum;

   logic          s1_start, s1_cin, s1_in_valid, s1_out_ready;
   logic [W-1:0]  s1_a, s1_b;
   logic          s1_in_ready, s1_out_valid, s1_carryout, s1_carryoutf, s1_busy, s1_done;
   logic [W-1:0]  s1_sum;

   int total = 0;
   int bad   = 0;

   logic [W-1:0]  op_a [NW];
   logic [W-1:0]  op_b [NW];
   logic [W-1:0]  exp_sum [NW];
   logic          exp_co [NW];
   logic          exp_cof;

   logic [W-1:0]  got_sum [$];
   logic          got_co [$];
   int            stall_bad, early_done, cyc_count;
   bit            timed_out;
   logic          done_at_end, done_after, busy_after, cof_after;

   carry_chain_seq #(.WIDTH(W), .NWORDS(NW)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .cin_init(cin_init),
      .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
      .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
      .carryout(carryout), .carryoutf(carryoutf), .busy(busy), .done(done)
   );

   carry_chain_seq #(.WIDTH(W), .NWORDS(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(s1_start), .cin_init(s1_cin),
      .in_valid(s1_in_valid), .in_ready(s1_in_ready), .a(s1_a), .b(s1_b),
      .out_valid(s1_out_valid), .out_ready(s1_out_ready), .sum(s1_sum),
      .carryout(s1_carryout), .carryoutf(s1_carryoutf), .busy(s1_busy), .done(s1_done)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, bad=%0d", bad);
      $fatal(1, "[TB] watchdog expired");
   end

   // Reference: treat the operands as two wide integers and add them in one go.
   task automatic model(input logic cin);
      logic [NW*W:0] big_a, big_b, whole, mask, part;
      big_a = '0;
      big_b = '0;
      for (int i = 0; i < NW; i++) begin
         big_a[i*W +: W] = op_a[i];
         big_b[i*W +: W] = op_b[i];
      end
      whole = big_a + big_b + {{NW*W{1'b0}}, cin};
      for (int i = 0; i < NW; i++) begin
         exp_sum[i] = whole[i*W +: W];
         mask = ({{NW*W{1'b0}}, 1'b1} << ((i + 1) * W)) - 1'b1;
         part = (big_a & mask) + (big_b & mask) + {{NW*W{1'b0}}, cin};
         exp_co[i] = part[(i + 1) * W];
      end
      exp_cof = whole[NW*W];
   endtask

   task automatic random_operands();
      logic [63:0] r;
      for (int i = 0; i < NW; i++) begin
         r = {$urandom(), $urandom()};
         op_a[i] = ($urandom_range(0, 3) == 0) ? '1 : r[W-1:0];
         r = {$urandom(), $urandom()};
         op_b[i] = ($urandom_range(0, 3) == 0) ? '0 : r[W-1:0];
      end
   endtask

   // Drives one full operation and records what came out; the tests judge it.
   task automatic run_op(input logic cin, input int stall_at, input int stall_len,
                         input bit poke_start);
      int in_idx, out_idx, stall_cnt;
      bit acc_in, acc_out;
      logic [W-1:0] hold_sum;
      logic hold_co;
      got_sum.delete();
      got_co.delete();
      stall_bad = 0; early_done = 0; cyc_count = 0; timed_out = 0;
      in_idx = 0; out_idx = 0; stall_cnt = 0;
      hold_sum = '0; hold_co = 1'b0;
      @(negedge clk);
      start = 1'b1; cin_init = cin;
      @(negedge clk);
      start = 1'b0; cin_init = 1'b0;
      while (out_idx < NW && cyc_count < 100) begin
         start    = poke_start && (in_idx == 1 || in_idx == NW);
         cin_init = start;
         out_ready = !(out_idx == stall_at && out_valid && stall_cnt < stall_len);
         in_valid = (in_idx < NW);
         a = (in_idx < NW) ? op_a[in_idx] : '0;
         b = (in_idx < NW) ? op_b[in_idx] : '0;
         #1;
         if (!out_ready) begin
            if (stall_cnt == 0) begin
               hold_sum = sum;
               hold_co  = carryout;
            end else if (sum !== hold_sum || carryout !== hold_co || out_valid !== 1'b1) begin
               stall_bad++;
            end
            if (in_ready !== 1'b0) stall_bad++;
            stall_cnt++;
         end
         if (done !== 1'b0) early_done++;
         acc_in  = in_valid && in_ready;
         acc_out = out_valid && out_ready;
         if (acc_out) begin
            got_sum.push_back(sum);
            got_co.push_back(carryout);
         end
         @(posedge clk);
         if (acc_in)  in_idx++;
         if (acc_out) out_idx++;
         @(negedge clk);
         cyc_count++;
      end
      timed_out = (out_idx < NW);
      start = 1'b0; cin_init = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      #1;
      done_at_end = done;
      busy_after  = busy;
      cof_after   = carryoutf;
      @(negedge clk);
      #1;
      done_after = done;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; cin_init = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0;
      s1_start = 1'b0; s1_cin = 1'b0; s1_in_valid = 1'b0; s1_out_ready = 1'b0;
      s1_a = '0; s1_b = '0;
      #1;
      total++;
      if ({out_valid, carryout, carryoutf, busy, done, in_ready} !== 6'b0) begin
         bad++;
         $display("[TB] FAIL reset_flags: got %b want 000000",
                  {out_valid, carryout, carryoutf, busy, done, in_ready});
      end
      total++;
      if (sum !== '0) begin bad++; $display("[TB] FAIL reset_sum: got %h want 0", sum); end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_basic_chain();
      op_a[0] = 48'hFFFF_FFFF_FFFF; op_b[0] = 48'h1;
      for (int i = 1; i < NW; i++) begin op_a[i] = '0; op_b[i] = '0; end
      model(1'b0);
      run_op(1'b0, -1, 0, 1'b0);
      total++;
      if (timed_out) begin bad++; $display("[TB] FAIL basic_timeout: got %0d words want %0d", got_sum.size(), NW); end
      for (int i = 0; i < NW && i < got_sum.size(); i++) begin
         total++;
         if (got_sum[i] !== exp_sum[i] || got_co[i] !== exp_co[i]) begin
            bad++;
            $display("[TB] FAIL basic_word%0d: got %h/%b want %h/%b", i, got_sum[i], got_co[i], exp_sum[i], exp_co[i]);
         end
      end
      total++;
      if (cof_after !== exp_cof) begin bad++; $display("[TB] FAIL basic_carryoutf: got %b want %b", cof_after, exp_cof); end
      total++;
      if ({early_done, done_at_end, done_after} !== {32'd0, 1'b1, 1'b0}) begin
         bad++;
         $display("[TB] FAIL basic_done: got early=%0d end=%b after=%b want 0/1/0", early_done, done_at_end, done_after);
      end
      total++;
      if (cyc_count != NW + 1 || busy_after !== 1'b0) begin
         bad++;
         $display("[TB] FAIL basic_throughput: got cycles=%0d busy=%b want %0d/0", cyc_count, busy_after, NW + 1);
      end
   endtask

   task automatic test_final_overflow();
      for (int i = 0; i < NW; i++) begin op_a[i] = '1; op_b[i] = '0; end
      model(1'b1);
      run_op(1'b1, -1, 0, 1'b0);
      for (int i = 0; i < NW && i < got_sum.size(); i++) begin
         total++;
         if (got_sum[i] !== exp_sum[i] || got_co[i] !== exp_co[i]) begin
            bad++;
            $display("[TB] FAIL overflow_word%0d: got %h/%b want %h/%b", i, got_sum[i], got_co[i], exp_sum[i], exp_co[i]);
         end
      end
      total++;
      if (timed_out || cof_after !== 1'b1) begin
         bad++;
         $display("[TB] FAIL overflow_carryoutf: got %b timeout=%0d want 1", cof_after, timed_out);
      end
   endtask

   task automatic test_random_ops();
      logic cin;
      for (int n = 0; n < 20; n++) begin
         random_operands();
         cin = 1'($urandom_range(0, 1));
         model(cin);
         run_op(cin, -1, 0, 1'b0);
         total++;
         if (timed_out || got_sum.size() != NW) begin
            bad++;
            $display("[TB] FAIL random%0d_count: got %0d words want %0d", n, got_sum.size(), NW);
         end
         for (int i = 0; i < NW && i < got_sum.size(); i++) begin
            total++;
            if (got_sum[i] !== exp_sum[i] || got_co[i] !== exp_co[i]) begin
               bad++;
               $display("[TB] FAIL random%0d_word%0d: got %h/%b want %h/%b", n, i, got_sum[i], got_co[i], exp_sum[i], exp_co[i]);
            end
         end
         total++;
         if (cof_after !== exp_cof || done_at_end !== 1'b1) begin
            bad++;
            $display("[TB] FAIL random%0d_final: got cof=%b done=%b want %b/1", n, cof_after, done_at_end, exp_cof);
         end
      end
   endtask

   task automatic test_backpressure();
      random_operands();
      op_a[0] = '1; op_b[0] = 48'h1;
      model(1'b1);
      run_op(1'b1, 1, 5, 1'b0);
      total++;
      if (stall_bad != 0) begin bad++; $display("[TB] FAIL stall_hold: got %0d violations want 0", stall_bad); end
      total++;
      if (cyc_count != NW + 1 + 5) begin bad++; $display("[TB] FAIL stall_cycles: got %0d want %0d", cyc_count, NW + 6); end
      for (int i = 0; i < NW && i < got_sum.size(); i++) begin
         total++;
         if (got_sum[i] !== exp_sum[i] || got_co[i] !== exp_co[i]) begin
            bad++;
            $display("[TB] FAIL stall_word%0d: got %h/%b want %h/%b", i, got_sum[i], got_co[i], exp_sum[i], exp_co[i]);
         end
      end
   endtask

   task automatic test_start_busy();
      for (int i = 0; i < NW; i++) begin op_a[i] = '1; op_b[i] = '0; end
      model(1'b0);
      run_op(1'b0, -1, 0, 1'b1);
      for (int i = 0; i < NW && i < got_sum.size(); i++) begin
         total++;
         if (got_sum[i] !== exp_sum[i] || got_co[i] !== exp_co[i]) begin
            bad++;
            $display("[TB] FAIL busystart_word%0d: got %h/%b want %h/%b", i, got_sum[i], got_co[i], exp_sum[i], exp_co[i]);
         end
      end
      total++;
      if (busy_after !== 1'b0 || cof_after !== exp_cof) begin
         bad++;
         $display("[TB] FAIL busystart_idle: got busy=%b cof=%b want 0/%b", busy_after, cof_after, exp_cof);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < NW; i++) begin op_a[i] = '1; op_b[i] = '0; end
      model(1'b1);
      run_op(1'b1, -1, 0, 1'b0);
      total++;
      if (got_sum.size() == 0 || got_sum[0] !== exp_sum[0] || got_co[0] !== exp_co[0]) begin
         bad++;
         $display("[TB] FAIL restart_word0: got %0d words want cin-propagated %h/%b", got_sum.size(), exp_sum[0], exp_co[0]);
      end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      start = 1'b1; cin_init = 1'b0;
      @(negedge clk);
      start = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; a = W'(i + 1); b = 48'h2;
         @(negedge clk);
      end
      in_valid = 1'b0;
      #1;
      total++;
      if (out_valid !== 1'b1 || sum !== 48'h5 || carryoutf !== 1'b1) begin
         bad++;
         $display("[TB] FAIL midop_inflight: got v=%b sum=%h cof=%b want 1/5/1", out_valid, sum, carryoutf);
      end
      #1 rst_n = 1'b0;
      #1;
      total++;
      if ({out_valid, carryout, carryoutf, busy, in_ready} !== 5'b0 || sum !== '0) begin
         bad++;
         $display("[TB] FAIL midop_reset: got flags=%b sum=%h want 0/0",
                  {out_valid, carryout, carryoutf, busy, in_ready}, sum);
      end
      @(negedge clk);
      rst_n = 1'b1;
      random_operands();
      model(1'b0);
      run_op(1'b0, -1, 0, 1'b0);
      for (int i = 0; i < NW && i < got_sum.size(); i++) begin
         total++;
         if (got_sum[i] !== exp_sum[i] || got_co[i] !== exp_co[i]) begin
            bad++;
            $display("[TB] FAIL postreset_word%0d: got %h/%b want %h/%b", i, got_sum[i], got_co[i], exp_sum[i], exp_co[i]);
         end
      end
   endtask

   task automatic test_nwords1();
      @(negedge clk);
      s1_start = 1'b1; s1_cin = 1'b0;
      @(negedge clk);
      s1_start = 1'b0; s1_in_valid = 1'b1; s1_out_ready = 1'b1;
      s1_a = 48'h8000_0000_0000; s1_b = 48'h8000_0000_0000;
      #1;
      total++;
      if (s1_in_ready !== 1'b1) begin bad++; $display("[TB] FAIL n1_ready: got %b want 1", s1_in_ready); end
      @(negedge clk);
      s1_in_valid = 1'b0;
      #1;
      total++;
      if (s1_sum !== '0 || s1_carryout !== 1'b1 || s1_carryoutf !== 1'b1 || s1_out_valid !== 1'b1 || s1_done !== 1'b0) begin
         bad++;
         $display("[TB] FAIL n1_result: got sum=%h co=%b cof=%b v=%b done=%b want 0/1/1/1/0",
                  s1_sum, s1_carryout, s1_carryoutf, s1_out_valid, s1_done);
      end
      @(negedge clk);
      #1;
      total++;
      if (s1_done !== 1'b1 || s1_out_valid !== 1'b0 || s1_busy !== 1'b0) begin
         bad++;
         $display("[TB] FAIL n1_done: got done=%b v=%b busy=%b want 1/0/0", s1_done, s1_out_valid, s1_busy);
      end
      @(negedge clk);
      #1;
      total++;
      if (s1_done !== 1'b0 || s1_carryoutf !== 1'b1) begin
         bad++;
         $display("[TB] FAIL n1_after: got done=%b cof=%b want 0/1", s1_done, s1_carryoutf);
      end
   endtask

   initial begin
      test_reset();
      test_basic_chain();
      test_final_overflow();
      test_random_ops();
      test_backpressure();
      test_start_busy();
      test_back_to_back();
      test_reset_mid();
      test_nwords1();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/carry_chain_seq.md
Name: carry_chain_seq

Overview:
- Multi-word carry-propagating adder sequencer: the producer end of the DSP48A1 carry path.
- Computes a (NWORDS×WIDTH)-bit sum word by word, least significant word first.
- Each word's carry-out is registered and fed back as the next word's carry-in.
- Sits between an operand streamer and the post-adder result path. Drives CARRYOUT/CARRYOUTF-style outputs for downstream cascade.

Parameters:
- WIDTH, 48, data width of one word (post-adder width).
- NWORDS, 4, number of words per wide operation (≥1).
- CNT_W, $clog2(NWORDS)+1, word counter width (derived; not overridden).

Ports:
- clk, input, 1, single clock; all state on rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, begin a wide operation; sampled only in IDLE.
- cin_init, input, 1, carry-in for word 0 (captured on start).
- in_valid, input, 1, operand word valid.
- in_ready, output, 1, operand word accepted when in_valid&in_ready.
- a, input, WIDTH, operand A word.
- b, input, WIDTH, operand B word.
- out_valid, output, 1, sum word valid.
- out_ready, input, 1, consumer accepts sum word when out_valid&out_ready.
- sum, output, WIDTH, sum word.
- carryout, output, 1, carry-out of the word currently on sum.
- carryoutf, output, 1, final carry of the last completed operation; holds until next start.
- busy, output, 1, high in RUN or DRAIN.
- done, output, 1, one-cycle pulse when the last sum word is accepted.

Behaviour:
- Interface: clk/rst_n, single clock; reset asynchronous, active-low.
- Reset (async assert, sync-released use):
  - state=IDLE; carry_reg, word_cnt, sum, carryout, carryoutf, out_valid, done all 0.
  - in_ready=0, busy=0.
- States:
  - IDLE: in_ready=0. On start=1: carry_reg<=cin_init, word_cnt<=0, go RUN. start is ignored outside IDLE.
  - RUN: in_ready = !out_valid || out_ready (single-entry output buffer).
    - On accept: {c,s} = a + b + carry_reg, computed in WIDTH+1 bits.
    - Register sum<=s, carryout<=c, carry_reg<=c, out_valid<=1, word_cnt++.
    - Accepting the word with word_cnt==NWORDS-1 also loads carryoutf<=c and goes DRAIN.
  - DRAIN: in_ready=0. When out_valid&out_ready: out_valid<=0, done<=1 for one cycle, go IDLE.
- out_valid:
  - Cleared in RUN when out_ready=1 and no new word is accepted that cycle.
  - Accept and drain in the same cycle gives back-to-back throughput: 1 word/clk.
- Latency: operand accept to sum valid is 1 cycle.
- Backpressure: while out_ready=0, sum, carryout and out_valid hold stable and in_ready=0.
- Wrap-around:
  - All-ones + 0 with carry 1 gives sum=0, carryout=1; the carry propagates into the next word.
  - Final-word overflow appears only on carryoutf; there is no extra word.
- NWORDS=1: the first accept goes directly to DRAIN.
- start while busy: ignored; no effect on carry_reg or word_cnt.
- start in the same cycle as done: start is sampled in DRAIN, so it is ignored. A new operation needs start in IDLE.
- Reset mid-operation: returns to IDLE with all outputs 0. The partial operation is discarded; carryoutf is cleared.
- busy = (state!=IDLE).

Decomposition:
- Shared package dsp_pkg:
  - state enum {IDLE, RUN, DRAIN}.
  - Default WIDTH=48 constant.
- Sub-module add_word_cy (WIDTH): combinational a+b+cin → {cout, s}.
  - Isolates the arithmetic so it can later be swapped for the post-adder.
- Control, registers and FSM stay in carry_chain_seq.

Test Plan:
1. Basic carry chain (WIDTH=48, NWORDS=4), cin_init=0:
   - Stimulus: word0 a=48'hFFFF_FFFF_FFFF, b=1; words 1–3 a=0, b=0; out_ready=1.
   - Required: sums 0,1,0,0; carryout 1,0,0,0; carryoutf=0; done pulse 1 cycle after the 4th accept.
2. Final overflow:
   - Stimulus: all four words a=all-ones, b=0, cin_init=1.
   - Required: every sum=0, every carryout=1, carryoutf=1.
3. Backpressure:
   - Stimulus: hold out_ready=0 for 5 cycles after word1.
   - Required: in_ready=0; sum and carryout stable for all 5 cycles. Release gives 1 word/clk and results identical to unstalled.
4. Start ignored while busy:
   - Stimulus: pulse start with cin_init=1 during RUN.
   - Required: no change to results.
   - Stimulus: start in IDLE after done.
   - Required: new operation begins with carry=cin_init.
5. Reset mid-operation:
   - Stimulus: drop rst_n after word 2 accepted.
   - Required: out_valid, sum, carryout and carryoutf are 0 immediately (async), busy=0.
   - Required: the next operation produces correct results from word 0.
6. NWORDS=1:
   - Stimulus: a=48'h8000_0000_0000, b=48'h8000_0000_0000.
   - Required: sum=0, carryout=1, carryoutf=1; done follows the single accept.
